reg_axi_master: RTL and testbench
=================================

# reg_axi_master

Single-outstanding AXI4-Lite initiator. It turns a simple valid/ready register request (read or write, 32-bit address and data) into one AXI4-Lite transaction and returns the response, including bresp/rresp and a timeout indication. It drives the slave-side register bridge of the latency-measurement register banks from local sequencing logic (bring-up sequencer, test bench, or an embedded controller) without a soft processor.

## Interface
- TIMEOUT_CYCLES, 1024, cycles allowed from the first AXI valid assertion to the final AXI handshake; 0 disables the timeout.
- aclk  in  1  single clock for all logic.
- areset  in  1  asynchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  high only in IDLE.
- req_wr  in  1  1 = write, 0 = read.
- req_addr  in  32  byte address.
- req_wdata  in  32  write data.
- req_wstrb  in  4  write strobes; ignored for reads.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  response consumed.
- rsp_rdata  out  32  read data; 0 for writes and for timeouts.
- rsp_resp  out  2  bresp or rresp as received; 2'b10 on timeout.
- rsp_timeout  out  1  transaction abandoned by the timeout.
- m_axi_awaddr/awprot/awvalid  out  32/3/1, and m_axi_awready  in  1.
- m_axi_wdata/wstrb/wvalid  out  32/4/1, and m_axi_wready  in  1.
- m_axi_bresp  in  2, m_axi_bvalid  in  1, m_axi_bready  out  1.
- m_axi_araddr/arprot/arvalid  out  32/3/1, and m_axi_arready  in  1.
- m_axi_rdata  in  32, m_axi_rresp  in  2, m_axi_rvalid  in  1, m_axi_rready  out  1.

## Operation
- States: IDLE, WR_AW_W, WR_B, RD_AR, RD_R, RESP.
- IDLE:
  - req_ready = 1.
  - On req_valid, latch addr, wdata, wstrb and wr.
  - Go to WR_AW_W if wr = 1, otherwise RD_AR.
- WR_AW_W:
  - awvalid and wvalid are asserted together on entry.
  - Each one drops independently on its own handshake (valid && ready); per-channel "done" flags track this.
  - When both channels are done (both may complete in the same cycle), go to WR_B.
- WR_B:
  - bready = 1.
  - On bvalid, capture bresp and go to RESP.
- RD_AR: arvalid = 1 until arready, then go to RD_R.
- RD_R:
  - rready = 1.
  - On rvalid, capture rdata and rresp and go to RESP.
- RESP:
  - rsp_valid = 1, with data held stable until rsp_ready.
  - On rsp_ready, go to IDLE.
- awprot and arprot are tied to 3'b000.
- awaddr, araddr, wdata and wstrb come from the latched registers and are stable while the corresponding valid is high.
- Timeout counter (16 bits, saturating):
  - Cleared in IDLE.
  - Increments every cycle in WR_AW_W, WR_B, RD_AR and RD_R.
  - When it equals TIMEOUT_CYCLES (nonzero), all m_axi valid/ready outputs drop on the next edge and the block enters RESP with rsp_resp = 2'b10, rsp_timeout = 1 and rsp_rdata = 0.
  - A handshake in the same cycle as the timeout wins: the normal transition is taken and no timeout is reported.
  - Abandoning a transaction is a deliberate AXI rule break. It is reserved for a dead slave, and software must reset the interconnect afterwards.
- rsp_timeout and rsp_resp are updated only on entry to RESP.
- Reset (asynchronous, any state):
  - State goes to IDLE.
  - All m_axi valid/ready outputs and rsp_valid are 0.
  - rsp_rdata, rsp_resp, rsp_timeout and the latched address/data are 0.
  - req_ready is 1 once areset deasserts.
  - A transaction in flight is dropped without a response.

## Timing
- All outputs are registered except req_ready, which is decoded from state.
- Request accepted at edge N: AXI valids are high from cycle N+1.
- Zero-wait slave, write:
  - aw/w handshake in cycle N+1.
  - bready high in cycle N+2; bvalid in N+2 gives rsp_valid in cycle N+3.
- Zero-wait slave, read:
  - ar handshake in cycle N+1, rready in N+2.
  - rvalid in N+2 gives rsp_valid in cycle N+3.
- Back-to-back: req_ready returns the cycle after the rsp_valid && rsp_ready edge. Minimum period is 4 cycles per transaction when rsp_ready is held high.
- Slave stalls add cycles one-for-one.
- Timeout fires TIMEOUT_CYCLES cycles after the first valid assertion, plus 1 cycle to RESP.
- bready and rready are never asserted outside WR_B and RD_R.

## Test plan
- Zero-wait write of addr 0x10, data 0xA5A5_0001, strb 0xF:
  - awvalid and wvalid rise 1 cycle after acceptance.
  - rsp_valid appears 3 cycles after acceptance with rsp_resp = 0 and rsp_rdata = 0.
- Read of 0x24 where the slave returns rdata 0x1234_5678, rresp 2'b00 after 5 wait cycles on arready and 3 on rvalid:
  - rsp_rdata = 0x1234_5678.
  - arvalid stays high until arready; rready is never high before the ar handshake.
- Skewed write channels (wready 4 cycles before awready, then the reverse order):
  - wvalid drops exactly after its own handshake.
  - bready is asserted only after both channels are done; bresp 2'b10 is reported as rsp_resp = 2'b10.
- Timeout with TIMEOUT_CYCLES = 8 and the slave never asserting arready:
  - arvalid drops after 8 cycles.
  - rsp_valid with rsp_timeout = 1, rsp_resp = 2'b10, rsp_rdata = 0.
  - The next request proceeds normally.
- Response backpressure (rsp_ready low for 6 cycles):
  - rsp_valid and the response data stay stable.
  - req_ready stays 0 until the rsp handshake.
- areset asserted in WR_B:
  - All valid/ready outputs and rsp_valid go to 0 immediately.
  - req_ready = 1 after release.
  - No stale response appears.

Source files
------------

// File: rtl/reg_axi_master_if.sv
// Signal bundle for reg_axi_master: local register request/response port plus the
// AXI4-Lite master channels. "master" is the initiator's view, "slave" the environment's.
interface reg_axi_master_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_wr;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_wstrb;

    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_resp;
    logic        rsp_timeout;

    logic [31:0] m_axi_awaddr;
    logic [2:0]  m_axi_awprot;
    logic        m_axi_awvalid;
    logic        m_axi_awready;
    logic [31:0] m_axi_wdata;
    logic [3:0]  m_axi_wstrb;
    logic        m_axi_wvalid;
    logic        m_axi_wready;
    logic [1:0]  m_axi_bresp;
    logic        m_axi_bvalid;
    logic        m_axi_bready;
    logic [31:0] m_axi_araddr;
    logic [2:0]  m_axi_arprot;
    logic        m_axi_arvalid;
    logic        m_axi_arready;
    logic [31:0] m_axi_rdata;
    logic [1:0]  m_axi_rresp;
    logic        m_axi_rvalid;
    logic        m_axi_rready;

    modport master (
        input  req_valid, req_wr, req_addr, req_wdata, req_wstrb, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_resp, rsp_timeout,
        output m_axi_awaddr, m_axi_awprot, m_axi_awvalid, input m_axi_awready,
        output m_axi_wdata, m_axi_wstrb, m_axi_wvalid, input m_axi_wready,
        input  m_axi_bresp, m_axi_bvalid, output m_axi_bready,
        output m_axi_araddr, m_axi_arprot, m_axi_arvalid, input m_axi_arready,
        input  m_axi_rdata, m_axi_rresp, m_axi_rvalid, output m_axi_rready
    );

    modport slave (
        output req_valid, req_wr, req_addr, req_wdata, req_wstrb, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_resp, rsp_timeout,
        input  m_axi_awaddr, m_axi_awprot, m_axi_awvalid, output m_axi_awready,
        input  m_axi_wdata, m_axi_wstrb, m_axi_wvalid, output m_axi_wready,
        output m_axi_bresp, m_axi_bvalid, input m_axi_bready,
        input  m_axi_araddr, m_axi_arprot, m_axi_arvalid, output m_axi_arready,
        output m_axi_rdata, m_axi_rresp, m_axi_rvalid, input m_axi_rready
    );
endinterface

// File: rtl/reg_axi_master.sv
// Single-outstanding AXI4-Lite initiator: one register request in, one AXI4-Lite
// transaction out, and the bresp/rresp (or a timeout) returned on the rsp side.
module reg_axi_master #(
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input logic              aclk,
    input logic              areset,
    reg_axi_master_if.master bus
);

    typedef enum logic [2:0] {StIdle, StWrAwW, StWrB, StRdAr, StRdR, StResp} state_e;

    state_e      state_q, state_d;
    logic [31:0] addr_q, addr_d, wdata_q, wdata_d;
    logic [3:0]  wstrb_q, wstrb_d;
    logic [15:0] cnt_q, cnt_d;
    logic        awvalid_q, awvalid_d, wvalid_q, wvalid_d, bready_q, bready_d;
    logic        arvalid_q, arvalid_d, rready_q, rready_d;
    logic        rsp_valid_q, rsp_valid_d, rsp_timeout_q, rsp_timeout_d;
    logic [31:0] rsp_rdata_q, rsp_rdata_d;
    logic [1:0]  rsp_resp_q, rsp_resp_d;
    logic        timeout, abandon;

    assign timeout = (TIMEOUT_CYCLES != 0) && (32'(cnt_q) == TIMEOUT_CYCLES);

    always_comb begin
        state_d       = state_q;
        addr_d        = addr_q;
        wdata_d       = wdata_q;
        wstrb_d       = wstrb_q;
        cnt_d         = cnt_q;
        awvalid_d     = awvalid_q;
        wvalid_d      = wvalid_q;
        bready_d      = bready_q;
        arvalid_d     = arvalid_q;
        rready_d      = rready_q;
        rsp_valid_d   = rsp_valid_q;
        rsp_rdata_d   = rsp_rdata_q;
        rsp_resp_d    = rsp_resp_q;
        rsp_timeout_d = rsp_timeout_q;
        abandon       = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (bus.req_valid) begin
                    addr_d  = bus.req_addr;
                    wdata_d = bus.req_wdata;
                    wstrb_d = bus.req_wstrb;
                    if (bus.req_wr) begin
                        state_d   = StWrAwW;
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                    end else begin
                        state_d   = StRdAr;
                        arvalid_d = 1'b1;
                    end
                end
            end
            StWrAwW: begin
                // A channel whose valid is already low counts as done.
                awvalid_d = awvalid_q & ~bus.m_axi_awready;
                wvalid_d  = wvalid_q & ~bus.m_axi_wready;
                if (!awvalid_d && !wvalid_d) begin
                    state_d  = StWrB;
                    bready_d = 1'b1;
                end else if (timeout) begin
                    abandon = 1'b1;
                end
            end
            StWrB: begin
                if (bus.m_axi_bvalid) begin
                    state_d       = StResp;
                    bready_d      = 1'b0;
                    rsp_valid_d   = 1'b1;
                    rsp_rdata_d   = '0;
                    rsp_resp_d    = bus.m_axi_bresp;
                    rsp_timeout_d = 1'b0;
                end else if (timeout) begin
                    abandon = 1'b1;
                end
            end
            StRdAr: begin
                if (bus.m_axi_arready) begin
                    state_d   = StRdR;
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                end else if (timeout) begin
                    abandon = 1'b1;
                end
            end
            StRdR: begin
                if (bus.m_axi_rvalid) begin
                    state_d       = StResp;
                    rready_d      = 1'b0;
                    rsp_valid_d   = 1'b1;
                    rsp_rdata_d   = bus.m_axi_rdata;
                    rsp_resp_d    = bus.m_axi_rresp;
                    rsp_timeout_d = 1'b0;
                end else if (timeout) begin
                    abandon = 1'b1;
                end
            end
            StResp: begin
                if (bus.rsp_ready) begin
                    state_d     = StIdle;
                    rsp_valid_d = 1'b0;
                end
            end
            default: state_d = StIdle;
        endcase

        // Dead slave: drop every handshake signal and report SLVERR with the timeout flag.
        if (abandon) begin
            state_d       = StResp;
            awvalid_d     = 1'b0;
            wvalid_d      = 1'b0;
            bready_d      = 1'b0;
            arvalid_d     = 1'b0;
            rready_d      = 1'b0;
            rsp_valid_d   = 1'b1;
            rsp_rdata_d   = '0;
            rsp_resp_d    = 2'b10;
            rsp_timeout_d = 1'b1;
        end

        if (state_q == StIdle) begin
            cnt_d = '0;
        end else if (state_q != StResp) begin
            cnt_d = (&cnt_q) ? cnt_q : cnt_q + 16'd1;
        end
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state_q       <= StIdle;
            addr_q        <= '0;
            wdata_q       <= '0;
            wstrb_q       <= '0;
            cnt_q         <= '0;
            awvalid_q     <= 1'b0;
            wvalid_q      <= 1'b0;
            bready_q      <= 1'b0;
            arvalid_q     <= 1'b0;
            rready_q      <= 1'b0;
            rsp_valid_q   <= 1'b0;
            rsp_rdata_q   <= '0;
            rsp_resp_q    <= '0;
            rsp_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            addr_q        <= addr_d;
            wdata_q       <= wdata_d;
            wstrb_q       <= wstrb_d;
            cnt_q         <= cnt_d;
            awvalid_q     <= awvalid_d;
            wvalid_q      <= wvalid_d;
            bready_q      <= bready_d;
            arvalid_q     <= arvalid_d;
            rready_q      <= rready_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_rdata_q   <= rsp_rdata_d;
            rsp_resp_q    <= rsp_resp_d;
            rsp_timeout_q <= rsp_timeout_d;
        end
    end

    assign bus.req_ready     = (state_q == StIdle);
    assign bus.rsp_valid     = rsp_valid_q;
    assign bus.rsp_rdata     = rsp_rdata_q;
    assign bus.rsp_resp      = rsp_resp_q;
    assign bus.rsp_timeout   = rsp_timeout_q;
    assign bus.m_axi_awaddr  = addr_q;
    assign bus.m_axi_awprot  = 3'b000;
    assign bus.m_axi_awvalid = awvalid_q;
    assign bus.m_axi_wdata   = wdata_q;
    assign bus.m_axi_wstrb   = wstrb_q;
    assign bus.m_axi_wvalid  = wvalid_q;
    assign bus.m_axi_bready  = bready_q;
    assign bus.m_axi_araddr  = addr_q;
    assign bus.m_axi_arprot  = 3'b000;
    assign bus.m_axi_arvalid = arvalid_q;
    assign bus.m_axi_rready  = rready_q;

endmodule

// File: tb/tb_reg_axi_master.sv
// Bench for reg_axi_master: a stalling AXI4-Lite slave model, a response consumer with
// backpressure, and a scoreboard of expected responses. A second instance has a short timeout.
module tb_reg_axi_master;
    localparam int unsigned ToCycles = 8;

    typedef struct {
        logic [31:0] rdata;
        logic [1:0]  resp;
        logic        to;
        int          lat;
        int          acc;
    } exp_t;

    logic clk = 1'b0;
    logic areset;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Stimulus side, shared by both instances; sel picks which one is under test.
    logic        sel;
    logic        req_valid, req_wr, rsp_ready;
    logic [31:0] req_addr, req_wdata;
    logic [3:0]  req_wstrb;
    logic        awready, wready, bvalid, arready, rvalid;
    logic [1:0]  bresp, rresp;
    logic [31:0] rdata;

    reg_axi_master_if ba();
    reg_axi_master_if bt();

    reg_axi_master #(.TIMEOUT_CYCLES(1024)) u_dut_a (.aclk(clk), .areset(areset), .bus(ba.master));
    reg_axi_master #(.TIMEOUT_CYCLES(ToCycles)) u_dut_t (.aclk(clk), .areset(areset),
                                                          .bus(bt.master));

    assign ba.req_valid = req_valid & ~sel;
    assign bt.req_valid = req_valid & sel;
    assign ba.req_wr = req_wr;         assign bt.req_wr = req_wr;
    assign ba.req_addr = req_addr;     assign bt.req_addr = req_addr;
    assign ba.req_wdata = req_wdata;   assign bt.req_wdata = req_wdata;
    assign ba.req_wstrb = req_wstrb;   assign bt.req_wstrb = req_wstrb;
    assign ba.rsp_ready = rsp_ready & ~sel;
    assign bt.rsp_ready = rsp_ready & sel;
    assign ba.m_axi_awready = awready; assign bt.m_axi_awready = awready;
    assign ba.m_axi_wready = wready;   assign bt.m_axi_wready = wready;
    assign ba.m_axi_bvalid = bvalid;   assign bt.m_axi_bvalid = bvalid;
    assign ba.m_axi_bresp = bresp;     assign bt.m_axi_bresp = bresp;
    assign ba.m_axi_arready = arready; assign bt.m_axi_arready = arready;
    assign ba.m_axi_rvalid = rvalid;   assign bt.m_axi_rvalid = rvalid;
    assign ba.m_axi_rresp = rresp;     assign bt.m_axi_rresp = rresp;
    assign ba.m_axi_rdata = rdata;     assign bt.m_axi_rdata = rdata;

    logic        o_req_ready, o_rsp_valid, o_rsp_timeout;
    logic [31:0] o_rsp_rdata, o_awaddr, o_wdata, o_araddr;
    logic [1:0]  o_rsp_resp;
    logic [3:0]  o_wstrb;
    logic [2:0]  o_awprot, o_arprot;
    logic        o_awvalid, o_wvalid, o_bready, o_arvalid, o_rready;

    assign o_req_ready   = sel ? bt.req_ready     : ba.req_ready;
    assign o_rsp_valid   = sel ? bt.rsp_valid     : ba.rsp_valid;
    assign o_rsp_rdata   = sel ? bt.rsp_rdata     : ba.rsp_rdata;
    assign o_rsp_resp    = sel ? bt.rsp_resp      : ba.rsp_resp;
    assign o_rsp_timeout = sel ? bt.rsp_timeout   : ba.rsp_timeout;
    assign o_awaddr      = sel ? bt.m_axi_awaddr  : ba.m_axi_awaddr;
    assign o_awprot      = sel ? bt.m_axi_awprot  : ba.m_axi_awprot;
    assign o_awvalid     = sel ? bt.m_axi_awvalid : ba.m_axi_awvalid;
    assign o_wdata       = sel ? bt.m_axi_wdata   : ba.m_axi_wdata;
    assign o_wstrb       = sel ? bt.m_axi_wstrb   : ba.m_axi_wstrb;
    assign o_wvalid      = sel ? bt.m_axi_wvalid  : ba.m_axi_wvalid;
    assign o_bready      = sel ? bt.m_axi_bready  : ba.m_axi_bready;
    assign o_araddr      = sel ? bt.m_axi_araddr  : ba.m_axi_araddr;
    assign o_arprot      = sel ? bt.m_axi_arprot  : ba.m_axi_arprot;
    assign o_arvalid     = sel ? bt.m_axi_arvalid : ba.m_axi_arvalid;
    assign o_rready      = sel ? bt.m_axi_rready  : ba.m_axi_rready;

    int total = 0;
    int bad = 0;

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    exp_t        sb_q[$];
    int          aw_wait = 0, w_wait = 0, ar_wait = 0, r_wait = 0, b_wait = 0;
    logic [1:0]  cfg_bresp = 2'b00, cfg_rresp = 2'b00;
    logic [31:0] cfg_rdata = 32'h0;
    int          ar_hi = 0;
    int          rsp_delay = 0;
    logic [31:0] exp_addr = 32'h0, exp_wdata = 32'h0;
    logic [3:0]  exp_wstrb = 4'h0;

    // Slave model: each ready/valid appears after its configured number of wait cycles.
    initial begin
        int aw_c, w_c, ar_c, r_c, b_c;
        bit aw_pend, w_pend, ar_pend;
        aw_c = 0; w_c = 0; ar_c = 0; r_c = 0; b_c = 0;
        aw_pend = 0; w_pend = 0; ar_pend = 0;
        awready = 0; wready = 0; bvalid = 0; arready = 0; rvalid = 0;
        bresp = 0; rresp = 0; rdata = 0;
        forever begin
            @(posedge clk); #1;
            if (aw_pend) check_eq("awvalid_drop", o_awvalid, 0);
            if (w_pend)  check_eq("wvalid_drop", o_wvalid, 0);
            if (ar_pend) check_eq("arvalid_drop", o_arvalid, 0);
            check_eq("bready_excl", o_bready & (o_awvalid | o_wvalid | o_arvalid), 0);
            check_eq("rready_excl", o_rready & (o_arvalid | o_awvalid | o_wvalid), 0);
            if (o_awvalid) begin
                check_eq("awaddr_hold", {o_awprot, o_awaddr}, {3'b000, exp_addr});
                awready = (aw_c == aw_wait);
                aw_c++;
            end else begin
                awready = 0; aw_c = 0;
            end
            if (o_wvalid) begin
                check_eq("wdata_hold", {o_wstrb, o_wdata}, {exp_wstrb, exp_wdata});
                wready = (w_c == w_wait);
                w_c++;
            end else begin
                wready = 0; w_c = 0;
            end
            if (o_arvalid) begin
                check_eq("araddr_hold", {o_arprot, o_araddr}, {3'b000, exp_addr});
                arready = (ar_c == ar_wait);
                ar_c++;
                ar_hi++;
            end else begin
                arready = 0; ar_c = 0;
            end
            if (o_rready) begin
                rvalid = (r_c == r_wait);
                rdata  = rvalid ? cfg_rdata : 32'hDEAD_BEEF;
                rresp  = rvalid ? cfg_rresp : 2'b11;
                r_c++;
            end else begin
                rvalid = 0; r_c = 0;
            end
            if (o_bready) begin
                bvalid = (b_c == b_wait);
                bresp  = bvalid ? cfg_bresp : 2'b11;
                b_c++;
            end else begin
                bvalid = 0; b_c = 0;
            end
            aw_pend = o_awvalid && awready;
            w_pend  = o_wvalid && wready;
            ar_pend = o_arvalid && arready;
        end
    end

    // Response consumer: pops the scoreboard on first sight, checks hold stability.
    initial begin
        bit seen;
        int hold;
        logic [34:0] cap;
        exp_t e;
        seen = 0; hold = 0; cap = '0;
        rsp_ready = 0;
        forever begin
            @(posedge clk); #1;
            if (areset || !o_rsp_valid) begin
                seen = 0;
                rsp_ready = 0;
            end else begin
                if (!seen) begin
                    seen = 1;
                    hold = 0;
                    cap = {o_rsp_timeout, o_rsp_resp, o_rsp_rdata};
                    if (sb_q.size() == 0) begin
                        check_eq("stale_rsp", o_rsp_valid, 0);
                    end else begin
                        e = sb_q.pop_front();
                        check_eq("rsp_rdata", o_rsp_rdata, e.rdata);
                        check_eq("rsp_resp", o_rsp_resp, e.resp);
                        check_eq("rsp_timeout", o_rsp_timeout, e.to);
                        check_eq("rsp_latency", cyc - e.acc + 1, e.lat);
                    end
                end else begin
                    check_eq("rsp_stable", {o_rsp_timeout, o_rsp_resp, o_rsp_rdata}, cap);
                    check_eq("req_ready_bp", o_req_ready, 0);
                    hold++;
                end
                rsp_ready = (hold >= rsp_delay);
            end
        end
    end

    task automatic send_req(input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [3:0] strb, input logic [31:0] e_rdata,
                            input logic [1:0] e_resp, input bit e_to, input int e_lat,
                            output int acc);
        int n;
        exp_t e;
        n = 0;
        while (!o_req_ready && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        check_eq("req_ready_idle", o_req_ready, 1);
        req_valid = 1; req_wr = wr; req_addr = addr; req_wdata = wdata; req_wstrb = strb;
        exp_addr = addr; exp_wdata = wdata; exp_wstrb = strb;
        e.rdata = e_rdata; e.resp = e_resp; e.to = e_to; e.lat = e_lat; e.acc = 0;
        sb_q.push_back(e);
        @(posedge clk); #1;
        acc = cyc;
        sb_q[sb_q.size() - 1].acc = cyc;
        req_valid = 0; req_wr = 0; req_addr = 0; req_wdata = 0; req_wstrb = 0;
        if (wr) check_eq("aw_w_valid_n1", {o_awvalid, o_wvalid, o_arvalid}, 3'b110);
        else    check_eq("arvalid_n1", {o_awvalid, o_wvalid, o_arvalid}, 3'b001);
        check_eq("req_ready_busy", o_req_ready, 0);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((sb_q.size() != 0 || !o_req_ready) && n < 300) begin
            @(posedge clk); #1;
            n++;
        end
        check_eq("drain", sb_q.size(), 0);
    endtask

    initial begin
        int acc1, acc2;
        sel = 0; areset = 1;
        req_valid = 0; req_wr = 0; req_addr = 0; req_wdata = 0; req_wstrb = 0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("reset_outs", {o_rsp_valid, o_awvalid, o_wvalid, o_bready, o_arvalid,
                                o_rready, o_rsp_timeout, o_rsp_resp}, 0);
        check_eq("reset_data", {o_rsp_rdata, o_awaddr}, 0);
        areset = 0;
        @(posedge clk); #1;
        check_eq("req_ready_after_rst", o_req_ready, 1);

        // Zero-wait write, then two back-to-back zero-wait reads.
        send_req(1, 32'h10, 32'hA5A5_0001, 4'hF, 32'h0, 2'b00, 0, 3, acc1);
        wait_idle();
        cfg_rdata = 32'h0BAD_F00D;
        send_req(0, 32'h04, 32'h0, 4'h0, 32'h0BAD_F00D, 2'b00, 0, 3, acc1);
        send_req(0, 32'h08, 32'h0, 4'h0, 32'h0BAD_F00D, 2'b00, 0, 3, acc2);
        check_eq("b2b_period", acc2 - acc1, 4);
        wait_idle();

        // Read with stalls on both ar and r.
        ar_wait = 5; r_wait = 3; cfg_rdata = 32'h1234_5678; ar_hi = 0;
        send_req(0, 32'h24, 32'h0, 4'h0, 32'h1234_5678, 2'b00, 0, 11, acc1);
        wait_idle();
        check_eq("ar_stall_cycles", ar_hi, 6);
        ar_wait = 0; r_wait = 0;

        // Skewed write channels, both orders, slave reports SLVERR.
        cfg_bresp = 2'b10; aw_wait = 4; w_wait = 0;
        send_req(1, 32'h30, 32'h1111_2222, 4'h3, 32'h0, 2'b10, 0, 7, acc1);
        wait_idle();
        aw_wait = 0; w_wait = 4;
        send_req(1, 32'h34, 32'h3333_4444, 4'hC, 32'h0, 2'b10, 0, 7, acc1);
        wait_idle();
        w_wait = 0; cfg_bresp = 2'b00;

        // Read error response and response backpressure.
        cfg_rresp = 2'b11; cfg_rdata = 32'h5555_AAAA;
        send_req(0, 32'h38, 32'h0, 4'h0, 32'h5555_AAAA, 2'b11, 0, 3, acc1);
        wait_idle();
        cfg_rresp = 2'b00;
        rsp_delay = 6;
        send_req(1, 32'h40, 32'h7777_8888, 4'h5, 32'h0, 2'b00, 0, 3, acc1);
        wait_idle();
        rsp_delay = 0;

        // Dead slave on the short-timeout instance, then a normal read on it.
        sel = 1; ar_wait = 1000; ar_hi = 0;
        send_req(0, 32'h50, 32'h0, 4'h0, 32'h0, 2'b10, 1, ToCycles + 2, acc1);
        wait_idle();
        check_eq("timeout_ar_cycles", ar_hi, ToCycles + 1);
        ar_wait = 0; cfg_rdata = 32'hCAFE_0050;
        send_req(0, 32'h54, 32'h0, 4'h0, 32'hCAFE_0050, 2'b00, 0, 3, acc1);
        wait_idle();
        sel = 0;

        // Reset while waiting for bvalid: everything drops, no response ever shows up.
        b_wait = 100;
        send_req(1, 32'h60, 32'h9999_0000, 4'hF, 32'h0, 2'b00, 0, 3, acc1);
        for (int n = 0; n < 20 && !o_bready; n++) begin
            @(posedge clk); #1;
        end
        check_eq("in_wr_b", o_bready, 1);
        #2 areset = 1;
        #1;
        check_eq("async_rst_outs", {o_awvalid, o_wvalid, o_bready, o_arvalid, o_rready,
                                    o_rsp_valid}, 0);
        sb_q.delete();
        @(posedge clk); #1;
        areset = 0; b_wait = 0;
        @(posedge clk); #1;
        check_eq("req_ready_post_rst", o_req_ready, 1);
        repeat (5) @(posedge clk);
        #1;
        send_req(1, 32'h64, 32'h0123_4567, 4'hF, 32'h0, 2'b00, 0, 3, acc1);
        wait_idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: bench did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end
endmodule
